// File: rtl/digit_overlay_gen.sv
// Numeric overlay: renders DIGITS BCD glyphs from a bitmap ROM over a background colour.
// Optional leading-zero blanking is enabled by defining DIGIT_OVERLAY_LZB_EN.
module digit_overlay_gen #(
    parameter int         DIGITS     = 8,
    parameter int         GLYPH_W    = 32,
    parameter int         GLYPH_H    = 32,
    parameter int         ROM_STRIDE = 320,
    parameter int         ADDR_W     = 14,
    parameter int         ORG_X      = 0,
    parameter int         ORG_Y      = 0,
    parameter int         ROM_LAT    = 1,
    parameter logic [11:0] BG_RGB    = 12'hFFF
) (
    input  logic                  char_clock,
    input  logic                  reset_n,
    input  logic [11:0]           char_count,
    input  logic [11:0]           line_count,
    input  logic                  blank,
    input  logic [4*DIGITS-1:0]   bcd_cnt,
    input  logic [23:0]           bmp_data,
    output logic [ADDR_W-1:0]     bmp_adress,
    output logic [3:0]            red_out,
    output logic [3:0]            green_out,
    output logic [3:0]            blue_out
);
    localparam int GW_BITS = $clog2(GLYPH_W);
    localparam int K_BITS  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CALC_W  = ADDR_W + 2;

    logic [4*DIGITS-1:0] snap;
    logic [ROM_LAT:0]    win_pipe, vis_pipe, act_pipe;
    logic [11:0]         rel_x, rel_y;
    logic [K_BITS-1:0]   k;
    logic [3:0]          nib;
    logic                in_win, lead_ok, vis;
    logic [ADDR_W-1:0]   addr_next;
    logic                bmp_unused;
    int                  cx, cy;

    assign bmp_unused = ^{bmp_data[19:16], bmp_data[11:8], bmp_data[3:0]};

    always_comb begin
        cx     = int'(char_count);
        cy     = int'(line_count);
        in_win = (cx >= ORG_X) && (cx < ORG_X + DIGITS * GLYPH_W) &&
                 (cy >= ORG_Y) && (cy < ORG_Y + GLYPH_H);
        rel_x  = char_count - 12'(ORG_X);
        rel_y  = line_count - 12'(ORG_Y);
        k      = K_BITS'(rel_x >> GW_BITS);
    end

`ifdef DIGIT_OVERLAY_LZB_EN
    // sig[i]: some nibble at or left of digit i is non-zero; the last digit always shows.
    logic [DIGITS-1:0] sig;
    logic              seen;
    always_comb begin
        sig  = '0;
        seen = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            seen   = seen | (snap[4*(DIGITS-1-i) +: 4] != 4'd0) | (i == DIGITS - 1);
            sig[i] = seen;
        end
    end
`endif

    always_comb begin
        nib     = '0;
        lead_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (k == K_BITS'(i)) begin
                nib = snap[4*(DIGITS-1-i) +: 4];
`ifdef DIGIT_OVERLAY_LZB_EN
                lead_ok = sig[i];
`endif
            end
        end
        vis       = (nib <= 4'd9) && lead_ok;
        addr_next = ADDR_W'(CALC_W'(rel_y) * CALC_W'(ROM_STRIDE) +
                            CALC_W'(nib) * CALC_W'(GLYPH_W) +
                            CALC_W'(rel_x[GW_BITS-1:0]));
    end

    // Flags are delayed so they meet bmp_data, which trails the address by ROM_LAT clocks.
    always_ff @(posedge char_clock) begin
        if (!reset_n) begin
            snap       <= '0;
            bmp_adress <= '0;
            win_pipe   <= '0;
            vis_pipe   <= '0;
            act_pipe   <= '0;
            red_out    <= '0;
            green_out  <= '0;
            blue_out   <= '0;
        end else begin
            if (char_count == 12'd0 && line_count == 12'd0)
                snap <= bcd_cnt;
            bmp_adress <= in_win ? addr_next : '0;
            win_pipe   <= {win_pipe[ROM_LAT-1:0], in_win};
            vis_pipe   <= {vis_pipe[ROM_LAT-1:0], vis};
            act_pipe   <= {act_pipe[ROM_LAT-1:0], blank};
            if (!act_pipe[ROM_LAT]) begin
                {red_out, green_out, blue_out} <= 12'h000;
            end else if (win_pipe[ROM_LAT] && vis_pipe[ROM_LAT]) begin
                {red_out, green_out, blue_out} <= {bmp_data[7:4], bmp_data[15:12], bmp_data[23:20]};
            end else begin
                {red_out, green_out, blue_out} <= BG_RGB;
            end
        end
    end
endmodule

// File: tb/tb_digit_overlay_gen.sv
// Bench for digit_overlay_gen: two instances (ROM_LAT=1 and ROM_LAT=3) driven in lockstep,
// each fed by an address-tagged ROM model; a pixel model fills per-latency expected queues.
module tb_digit_overlay_gen;
    localparam int D = 8, GW = 32, GH = 32, STR = 320, OX = 0, OY = 0;
    localparam int W = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] char_count, line_count;
    logic        blank;
    logic [31:0] bcd_cnt;
    logic [23:0] bmp_data1, bmp_data3;
    logic [13:0] addr1, addr3;
    logic [3:0]  r1, g1, b1, r3, g3, b3;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp3_q[$];
    logic [13:0]   addr_q[$];
    logic [31:0]   snap_m;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    digit_overlay_gen #(.ROM_LAT(1)) dut (
        .char_clock(clk), .reset_n(reset_n), .char_count(char_count), .line_count(line_count),
        .blank(blank), .bcd_cnt(bcd_cnt), .bmp_data(bmp_data1), .bmp_adress(addr1),
        .red_out(r1), .green_out(g1), .blue_out(b1));

    digit_overlay_gen #(.ROM_LAT(3)) dut3 (
        .char_clock(clk), .reset_n(reset_n), .char_count(char_count), .line_count(line_count),
        .blank(blank), .bcd_cnt(bcd_cnt), .bmp_data(bmp_data3), .bmp_adress(addr3),
        .red_out(r3), .green_out(g3), .blue_out(b3));

    // ROM word tagged so that {red,green,blue} equals address[11:0]; unused bits carry junk.
    function automatic logic [23:0] rom_word(input logic [13:0] a);
        return {a[3:0], ~a[3:0], a[7:4], ~a[7:4], a[11:8], ~a[11:8]};
    endfunction

    logic [13:0] rom1_q;
    logic [13:0] rom3_q[3];
    always @(posedge clk) begin
        rom1_q    <= addr1;
        rom3_q[0] <= addr3;
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign bmp_data1 = rom_word(rom1_q);
    assign bmp_data3 = rom_word(rom3_q[2]);

    // Returns {address, rgb} for one pixel given the displayed snapshot.
    function automatic logic [25:0] model(input int x, input int y, input logic b, input logic [31:0] s);
        int k, dx, dy;
        logic in_w, seen, v;
        logic [3:0] n;
        logic [13:0] a;
        logic [11:0] rgb;
        in_w = (x >= OX) && (x < OX + D * GW) && (y >= OY) && (y < OY + GH);
        a = '0;
        v = 1'b0;
        if (in_w) begin
            k  = (x - OX) / GW;
            dx = (x - OX) % GW;
            dy = y - OY;
            n  = s[4*(D-1-k) +: 4];
            seen = 1'b0;
            for (int j = 0; j <= k; j++)
                if (s[4*(D-1-j) +: 4] != 4'd0) seen = 1'b1;
            v = (n <= 4'd9);
`ifdef DIGIT_OVERLAY_LZB_EN
            v = v && (seen || k == D - 1);
`endif
            a = 14'(dy * STR + int'(n) * GW + dx);
        end
        if (!b) rgb = 12'h000;
        else if (in_w && v) rgb = a[11:0];
        else rgb = 12'hFFF;
        return {a, rgb};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One pixel clock: compare outputs that are due, then drive the next pixel.
    task automatic step(input int x, input int y, input logic b, input logic [31:0] bcd,
                        input logic rst, input logic use_tbl,
                        input logic [13:0] t_addr, input logic [11:0] t_rgb);
        logic [25:0] m;
        logic [13:0] ea;
        logic [11:0] er;
        @(negedge clk);
        if (addr_q.size() > 0) begin
            ea = addr_q.pop_front();
            check("addr_lat1", {2'b0, addr1}, {2'b0, ea});
            check("addr_lat3", {2'b0, addr3}, {2'b0, ea});
        end
        if (exp_q.size() == 3) begin
            er = exp_q.pop_front();
            check("rgb_lat1", {4'b0, r1, g1, b1}, {4'b0, er});
        end
        if (exp3_q.size() == 5) begin
            er = exp3_q.pop_front();
            check("rgb_lat3", {4'b0, r3, g3, b3}, {4'b0, er});
        end
        reset_n    = !rst;
        char_count = 12'(x);
        line_count = 12'(y);
        blank      = b;
        bcd_cnt    = bcd;
        if (rst) begin
            foreach (exp_q[i]) exp_q[i] = '0;
            foreach (exp3_q[i]) exp3_q[i] = '0;
            snap_m = '0;
            ea = '0;
            er = '0;
        end else begin
            m  = model(x, y, b, snap_m);
            ea = use_tbl ? t_addr : m[25:12];
            er = use_tbl ? t_rgb : m[11:0];
            if (x == 0 && y == 0) snap_m = bcd;
        end
        addr_q.push_back(ea);
        exp_q.push_back(er);
        exp3_q.push_back(er);
    endtask

    task automatic px(input int x, input int y, input logic b, input logic [31:0] bcd);
        step(x, y, b, bcd, 1'b0, 1'b0, '0, '0);
    endtask

    typedef struct {
        int          x;
        int          y;
        logic        b;
        logic [13:0] addr;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs[11];

    initial begin
        logic [31:0] rb;
        vecs[0]  = '{40, 5, 1'b1, 14'd1672, 12'h688};
        vecs[1]  = '{255, 31, 1'b1, 14'd10207, 12'h7DF};
        vecs[2]  = '{256, 5, 1'b1, 14'd0, 12'hFFF};
        vecs[3]  = '{10, 32, 1'b1, 14'd0, 12'hFFF};
        vecs[4]  = '{300, 100, 1'b1, 14'd0, 12'hFFF};
        vecs[5]  = '{40, 5, 1'b0, 14'd1672, 12'h000};
        vecs[6]  = '{300, 100, 1'b0, 14'd0, 12'h000};
        vecs[7]  = '{31, 0, 1'b1, 14'd63, 12'h03F};
        vecs[8]  = '{32, 1, 1'b1, 14'd384, 12'h180};
        vecs[9]  = '{160, 10, 1'b1, 14'd3392, 12'hD40};
        vecs[10] = '{100, 31, 1'b1, 14'd10052, 12'h744};

        reset_n = 1'b0; char_count = '0; line_count = '0; blank = 1'b0; bcd_cnt = '0;
        snap_m = '0;
        for (int i = 0; i < 6; i++) step(300, 100, 1'b0, 32'h0, 1'b1, 1'b0, '0, '0);

        // Frame start loads 12345678, then the fixed vector table.
        px(0, 0, 1'b1, 32'h12345678);
        foreach (vecs[i])
            step(vecs[i].x, vecs[i].y, vecs[i].b, 32'h12345678, 1'b0, 1'b1, vecs[i].addr, vecs[i].rgb);

        // Mid-frame value change is held off until the next (0,0); capture-cycle change is taken.
        px(0, 0, 1'b1, 32'h00000001);
        px(230, 3, 1'b1, 32'h00000001);
        px(230, 3, 1'b1, 32'h00000002);
        px(231, 4, 1'b1, 32'h00000002);
        px(100, 3, 1'b1, 32'h00000001);
        px(0, 0, 1'b1, 32'h00000002);
        px(230, 3, 1'b1, 32'h00000002);
        px(231, 4, 1'b1, 32'h00000002);

        // Invalid nibble and leading zeros.
        px(0, 0, 1'b1, 32'h0000A012);
        for (int k = 0; k < D; k++) px(k * GW + 5, 4, 1'b1, 32'h0000A012);
        px(0, 0, 1'b1, 32'h00000000);
        for (int k = 0; k < D; k++) px(k * GW + 9, 7, 1'b1, 32'h00000000);

        // Reset mid-line: zero outputs, black refill, snapshot back to 0.
        px(0, 0, 1'b1, 32'h87654321);
        for (int x = 50; x < 56; x++) px(x, 7, 1'b1, 32'h87654321);
        for (int x = 56; x < 59; x++) step(x, 7, 1'b1, 32'h87654321, 1'b1, 1'b0, '0, '0);
        for (int x = 59; x < 70; x++) px(x, 7, 1'b1, 32'h87654321);
        for (int x = 220; x < 240; x++) px(x, 8, 1'b1, 32'h87654321);

        // Random pixels with occasional frame starts and random values.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 30) == 0) begin
                rb = $urandom() >> (4 * $urandom_range(0, 7));
                px(0, 0, 1'b1, rb);
            end else begin
                px($urandom_range(0, 300), $urandom_range(0, 40), $urandom_range(0, 7) != 0, $urandom());
            end
        end

        for (int i = 0; i < 6; i++) px(300, 100, 1'b0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/digit_overlay_gen.md
# digit_overlay_gen

Parametrised numeric overlay generator for the VGA path. It renders a row of DIGITS BCD digits from a glyph bitmap ROM at a configurable screen origin and fills the rest of the active area with a background colour. Compared with the previous overlay it adds configurable glyph geometry, frame-synchronous value capture (no tearing), invalid-digit handling, and ROM-latency-matched pipelining. It sits between the VGA timing counters and the colour DAC pins, alongside the built-in glyph memory.

## Interface
Parameters:
- DIGITS, 8: number of rendered digits (1..8).
- GLYPH_W, 32: glyph width in pixels (power of two, 8..64).
- GLYPH_H, 32: glyph height in lines.
- ROM_STRIDE, 320: pixels per ROM row (10 glyphs × GLYPH_W).
- ADDR_W, 14: ROM address width.
- ORG_X, 0 / ORG_Y, 0: top-left pixel of the overlay window.
- ROM_LAT, 1: ROM read latency in clocks (1..4).
- BG_RGB, 12'hFFF: background colour {r,g,b}, 4 bits each.

Ports:
- char_clock  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- char_count  in  12  horizontal pixel counter.
- line_count  in  12  vertical line counter.
- blank  in  1  1 = active video, 0 = blanking.
- bcd_cnt  in  4*DIGITS  value to display; MS digit in the top nibble.
- bmp_data  in  24  ROM data: blue [23:20], green [15:12], red [7:4].
- bmp_adress  out  ADDR_W  ROM address, registered.
- red_out, green_out, blue_out  out  4 each  registered colour.

## Operation
- Window: X in [ORG_X, ORG_X+DIGITS*GLYPH_W), Y in [ORG_Y, ORG_Y+GLYPH_H).
- dx = (char_count−ORG_X) mod GLYPH_W. dy = line_count−ORG_Y. Digit index k = (char_count−ORG_X)/GLYPH_W; k=0 is the MS nibble.
- Address inside window: dy*ROM_STRIDE + d_k*GLYPH_W + dx. Arithmetic is done at ≥ ADDR_W+2 bits, then truncated to ADDR_W. Outside the window bmp_adress = 0.
- Snapshot register: captures bcd_cnt on the cycle where char_count==0 && line_count==0. Only the snapshot is rendered.
- Nibble > 9: that digit cell is rendered as BG_RGB.
- Output selection, in priority order:
  - blank=0 → black (0,0,0).
  - in window and digit visible → ROM nibbles.
  - otherwise → BG_RGB.
- Pipeline: the in-window, digit-visible and blank flags pass through a ROM_LAT+1 stage shift register so they stay aligned with bmp_data.
- Reset:
  - bmp_adress = 0; all colour outputs = 0.
  - snapshot = 0; control pipeline cleared to blank=0.
  - A reset asserted mid-frame gives black output until the pipeline refills after release. Digits show snapshot 0 until the next frame start.

## Timing
- Cycle n: counters/blank sampled. Edge n+1: bmp_adress valid. bmp_data valid ROM_LAT cycles after the address. RGB registered one edge later.
- Total pixel latency L = ROM_LAT+2 clocks, identical for every path (black, BG, glyph). The VGA timing block delays its syncs by L.
- Snapshot update takes effect for pixels sampled from cycle n+1 onward, i.e. at the start of the frame. If bcd_cnt changes on the capture cycle itself, the new value is taken.
- Counter wrap: no special handling. Window tests use unsigned compares against ORG-based bounds, so char_count < ORG_X is out of window. There is no negative wrap-around.

## Configuration
- DIGIT_OVERLAY_LZB_EN defined: leading-zero blanking. Digits left of the first non-zero nibble render as BG_RGB. The least significant digit always renders, so 0 shows as a single "0". Invalid nibbles (>9) count as non-zero for finding the first significant digit.
- Undefined: all DIGITS digits render, including leading zeros. Gate count is reduced by the removed prefix logic.

## Test plan
- Default params, bcd_cnt=32'h12345678, ROM glyph pixels tagged with a unique pattern. Pixel (40,5) → bmp_adress = 5*320+2*32+8 = 1672. RGB matches the ROM nibbles at L=3 cycles later.
- blank=0 inside the window → RGB=0 after L cycles. Pixel (300,100) with blank=1 → RGB = F,F,F.
- bcd_cnt changes from 32'h00000001 to 32'h00000002 mid-frame. The displayed glyph changes only after the next (0,0) sample.
- bcd_cnt=32'h0000A012 → digit 4 (value A) is background. With LZB_EN, digits 0..3 are also background. Without it, "0000" renders.
- With LZB_EN, bcd_cnt=0 → only the k=7 cell shows glyph 0.
- reset_n low for 3 cycles mid-line → outputs and bmp_adress = 0 during reset. After release the output is black for L cycles and the snapshot reads 0. With ROM_LAT=3, alignment is rechecked with L=5.
